ref_filter_planar_stream: RTL

//  Parametrised planar reference pre-processor for intra prediction. Collects NREF top and NREF left

---
 rtl/ref_filter_planar_stream.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/ref_filter_planar_stream.sv
// Planar reference pre-processor: gathers NREF top + NREF left samples, optionally smooths them,
// and emits planar deltas. Define REF_FILTER_SMOOTH_EN to build the [1 2 1] smoothing filter.
module ref_filter_planar_stream #(
    parameter int BIT_DEPTH = 8,
    parameter int NREF      = 8
) (
    input  logic                            CLK1,
    input  logic                            RST_N,
    input  logic                            IN_VALID,
    output logic                            IN_READY,
    input  logic [BIT_DEPTH-1:0]            IN_DATA,
    input  logic                            SMOOTH_ON,
    output logic                            OUT_VALID,
    input  logic                            OUT_READY,
    output logic [NREF*(BIT_DEPTH+1)-1:0]   OUT_TOP,
    output logic [NREF*(BIT_DEPTH+1)-1:0]   OUT_LEFT
);

    localparam int OW   = BIT_DEPTH + 1;
    localparam int CW   = $clog2(2 * NREF);
    localparam int M    = NREF / 2;
    localparam logic [CW-1:0] LAST = CW'(2 * NREF - 1);

    typedef enum logic [1:0] {IDLE, LOAD, CALC, OUT} state_t;

    state_t                 state;
    state_t                 next_state;
    logic [CW-1:0]          cnt;
    logic                   live;
    logic                   accept;
    logic [BIT_DEPTH-1:0]   top_r  [NREF];
    logic [BIT_DEPTH-1:0]   left_r [NREF];
    logic [BIT_DEPTH-1:0]   top_s  [NREF];
    logic [BIT_DEPTH-1:0]   left_s [NREF];
    logic [NREF*OW-1:0]     calc_top;
    logic [NREF*OW-1:0]     calc_left;

    // live holds IN_READY low while reset is asserted and releases it on the first edge after
    assign IN_READY = live && (state == IDLE || state == LOAD);
    assign accept   = IN_VALID && IN_READY;

    always_ff @(posedge CLK1 or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
            live  <= 1'b0;
        end else begin
            state <= next_state;
            live  <= 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (accept) next_state = LOAD;
            LOAD: if (accept && cnt == LAST) next_state = CALC;
            CALC: next_state = OUT;
            OUT:  if (OUT_VALID && OUT_READY) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK1 or negedge RST_N) begin
        if (!RST_N) begin
            cnt <= '0;
            for (int unsigned i = 0; i < NREF; i++) begin
                top_r[i]  <= '0;
                left_r[i] <= '0;
            end
        end else if (accept) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
            for (int unsigned i = 0; i < NREF; i++) begin
                if (cnt == CW'(i))        top_r[i]  <= IN_DATA;
                if (cnt == CW'(i + NREF)) left_r[i] <= IN_DATA;
            end
        end
    end

`ifdef REF_FILTER_SMOOTH_EN
    logic                   smooth_q;
    logic [BIT_DEPTH+1:0]   sum_t;
    logic [BIT_DEPTH+1:0]   sum_l;

    always_ff @(posedge CLK1 or negedge RST_N) begin
        if (!RST_N)                        smooth_q <= 1'b0;
        else if (accept && state == IDLE)  smooth_q <= SMOOTH_ON;
    end

    // end samples pass through unfiltered; interior samples take the rounded [1 2 1] average
    always_comb begin
        sum_t = '0;
        sum_l = '0;
        for (int unsigned i = 0; i < NREF; i++) begin
            top_s[i]  = top_r[i];
            left_s[i] = left_r[i];
        end
        if (smooth_q) begin
            for (int unsigned i = 1; i < NREF - 1; i++) begin
                sum_t = {2'b00, top_r[i-1]} + {1'b0, top_r[i], 1'b0}
                      + {2'b00, top_r[i+1]} + (BIT_DEPTH+2)'(2);
                sum_l = {2'b00, left_r[i-1]} + {1'b0, left_r[i], 1'b0}
                      + {2'b00, left_r[i+1]} + (BIT_DEPTH+2)'(2);
                top_s[i]  = sum_t[BIT_DEPTH+1:2];
                left_s[i] = sum_l[BIT_DEPTH+1:2];
            end
        end
    end
`else
    logic unused_smooth_on;
    assign unused_smooth_on = SMOOTH_ON;

    always_comb begin
        for (int unsigned i = 0; i < NREF; i++) begin
            top_s[i]  = top_r[i];
            left_s[i] = left_r[i];
        end
    end
`endif

    always_comb begin
        calc_top  = '0;
        calc_left = '0;
        for (int unsigned i = 0; i < NREF; i++) begin
            if (i < M) begin
                calc_top[i*OW +: OW]  = {1'b0, top_s[M]}  - {1'b0, top_s[i]};
                calc_left[i*OW +: OW] = {1'b0, left_s[M]} - {1'b0, left_s[i]};
            end else begin
                calc_top[i*OW +: OW]  = {1'b0, top_s[i]};
                calc_left[i*OW +: OW] = {1'b0, left_s[i]};
            end
        end
    end

    // results register on the CALC edge; OUT_VALID follows one edge later and drops on handshake
    always_ff @(posedge CLK1 or negedge RST_N) begin
        if (!RST_N) begin
            OUT_TOP   <= '0;
            OUT_LEFT  <= '0;
            OUT_VALID <= 1'b0;
        end else begin
            if (state == CALC) begin
                OUT_TOP  <= calc_top;
                OUT_LEFT <= calc_left;
            end
            if (state == OUT) begin
                if (!OUT_VALID)     OUT_VALID <= 1'b1;
                else if (OUT_READY) OUT_VALID <= 1'b0;
            end
        end
    end

endmodule
